// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
// Build option: define PC_C_EXT_EN for 16-bit compressed instruction support.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam int unsigned INC_32 = 4;
  localparam int unsigned INC_16 = 2;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

`ifdef PC_C_EXT_EN
  localparam bit C_EXT_EN = 1'b1;
`else
  localparam bit C_EXT_EN = 1'b0;
`endif

  // With compressed instructions, halfword-aligned targets are legal.
  function automatic logic is_misaligned(input logic [1:0] low);
    return C_EXT_EN ? low[0] : (low != 2'b00);
  endfunction

endpackage

// File: rtl/pc_if.sv
// Fetch and control bundle between the PC unit and the fetch/execute/CSR logic.
// Build option: PC_C_EXT_EN adds the insn_is_16 signal.
interface pc_if #(
  parameter int PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] pc_out;
  logic                pc_valid;
  logic                if_ready;
  logic                stall;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_target;
  logic                trap_valid;
  logic                mret_valid;
  logic                halt_req;
  logic                resume;
`ifdef PC_C_EXT_EN
  logic                insn_is_16;
`endif
  logic [PC_WIDTH-1:0] epc_out;
  logic                misalign_err;
  logic [1:0]          state_out;

  modport master (
    input  pc_out, pc_valid, epc_out, misalign_err, state_out,
`ifdef PC_C_EXT_EN
    output insn_is_16,
`endif
    output if_ready, stall, redirect_valid, redirect_target,
    output trap_valid, mret_valid, halt_req, resume
  );

  modport slave (
    output pc_out, pc_valid, epc_out, misalign_err, state_out,
`ifdef PC_C_EXT_EN
    input  insn_is_16,
`endif
    input  if_ready, stall, redirect_valid, redirect_target,
    input  trap_valid, mret_valid, halt_req, resume
  );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: trap > mret > redirect > sequential advance.
// Build option: PC_C_EXT_EN selects a 2-byte increment for 16-bit instructions.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] TRAP_VEC = PC_WIDTH'(DEF_TRAP_VEC)
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] epc,
  input  logic                trap,
  input  logic                mret,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_target,
  input  logic                advance,
`ifdef PC_C_EXT_EN
  input  logic                insn_is_16,
`endif
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                take_trap,
  output logic                misalign
);

  logic [PC_WIDTH-1:0] inc;

  always_comb begin
`ifdef PC_C_EXT_EN
    inc = insn_is_16 ? PC_WIDTH'(INC_16) : PC_WIDTH'(INC_32);
`else
    inc = PC_WIDTH'(INC_32);
`endif
  end

  // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    next_pc   = pc;
    take_trap = 1'b0;
    misalign  = 1'b0;
    if (trap) begin
      next_pc   = TRAP_VEC;
      take_trap = 1'b1;
    end else if (mret) begin
      if (is_misaligned(epc[1:0])) begin
        next_pc   = TRAP_VEC;
        take_trap = 1'b1;
        misalign  = 1'b1;
      end else begin
        next_pc = epc;
      end
    end else if (redirect) begin
      if (is_misaligned(redirect_target[1:0])) begin
        next_pc   = TRAP_VEC;
        take_trap = 1'b1;
        misalign  = 1'b1;
      end else begin
        next_pc = redirect_target;
      end
    end else if (advance) begin
      // Sum truncates to PC_WIDTH, so the PC wraps naturally.
      next_pc = pc + inc;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALT FSM, boot delay, fetch PC, saved EPC, misalign pulse.
// Build option: define PC_C_EXT_EN for 16-bit instruction increments and halfword alignment.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VEC   = PC_WIDTH'(DEF_RESET_VEC),
  parameter logic [PC_WIDTH-1:0] TRAP_VEC    = PC_WIDTH'(DEF_TRAP_VEC),
  parameter int                  BOOT_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  pc_if.slave bus
);

  localparam int CNT_W = $clog2(BOOT_CYCLES + 1);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  pc_state_e           state, state_nxt;
  logic [CNT_W-1:0]    boot_cnt;
  logic [PC_WIDTH-1:0] pc, epc, next_pc;
  logic                mis_q, take_trap, misalign;
  logic                sel_trap, sel_mret, sel_redir, sel_adv;

  // Mode gating: BOOT ignores everything, HALT only honours traps.
  always_comb begin
    sel_trap  = bus.trap_valid && (state != ST_BOOT);
    sel_mret  = bus.mret_valid && (state == ST_RUN);
    sel_redir = bus.redirect_valid && (state == ST_RUN);
    sel_adv   = (state == ST_RUN) && !bus.halt_req && bus.if_ready && !bus.stall;
  end

  pc_next_sel #(
    .PC_WIDTH (PC_WIDTH),
    .TRAP_VEC (TRAP_VEC)
  ) u_next_sel (
    .pc              (pc),
    .epc             (epc),
    .trap            (sel_trap),
    .mret            (sel_mret),
    .redirect        (sel_redir),
    .redirect_target (bus.redirect_target),
    .advance         (sel_adv),
`ifdef PC_C_EXT_EN
    .insn_is_16      (bus.insn_is_16),
`endif
    .next_pc         (next_pc),
    .take_trap       (take_trap),
    .misalign        (misalign)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_BOOT: if (boot_cnt == BOOT_LAST) state_nxt = ST_RUN;
      ST_RUN:  if (!(sel_trap || sel_mret || sel_redir) && bus.halt_req) state_nxt = ST_HALT;
      ST_HALT: if (sel_trap || bus.resume) state_nxt = ST_RUN;
      default: state_nxt = ST_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      boot_cnt <= '0;
      pc       <= RESET_VEC;
      epc      <= '0;
      mis_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= next_pc;
      mis_q <= misalign;
      if (take_trap) epc <= pc;
      if (state == ST_BOOT) boot_cnt <= boot_cnt + 1'b1;
    end
  end

  assign bus.pc_out       = pc;
  assign bus.pc_valid     = (state == ST_RUN);
  assign bus.epc_out      = epc;
  assign bus.misalign_err = mis_q;
  assign bus.state_out    = state;

endmodule
